// File: rtl/encoder_stream.sv
// encoder_stream: serialises every set bit of an S-bit request vector into its binary index, lowest first.
// Optional ENCODER_STREAM_EMPTY_FLAG_EN: an all-zero vector emits one beat flagged with out_empty.
module encoder_stream #(
    parameter  int logS = 4,
    localparam int S    = 2 ** logS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [S-1:0]    in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [logS-1:0] out,
    output logic            out_last,
    output logic [logS:0]   out_cnt,
    output logic            out_empty
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state_q;
    logic [S-1:0]    res_q;
    logic [S-1:0]    res_d;
    logic [logS:0]   cnt_q;
    logic [logS:0]   cnt_d;
    logic [logS-1:0] low_idx;
    logic            one_left;
    logic            empty_q;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        low_idx = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (res_q[i]) low_idx = i[logS-1:0];
        end
    end

    assign res_d    = res_q & (res_q - 1'b1);
    assign cnt_d    = cnt_q + 1'b1;
    assign one_left = (res_q != '0) && (res_d == '0);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign out       = low_idx;
    assign out_last  = (state_q == SCAN) && (one_left || empty_q);
    assign out_cnt   = cnt_q;
    assign out_empty = empty_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in != '0) begin
                            res_q   <= in;
                            cnt_q   <= '0;
                            empty_q <= 1'b0;
                            state_q <= SCAN;
                        end
`ifdef ENCODER_STREAM_EMPTY_FLAG_EN
                        else begin
                            res_q   <= '0;
                            cnt_q   <= '0;
                            empty_q <= 1'b1;
                            state_q <= SCAN;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        res_q <= res_d;
                        cnt_q <= cnt_d;
                        if (out_last) begin
                            empty_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_stream.sv
// Self-checking bench for encoder_stream (logS=4): scoreboard of expected beats plus directed corner sequences.
module tb_encoder_stream;

    localparam int LOGS = 4;
    localparam int S    = 2 ** LOGS;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [S-1:0]    in_vec;
    logic            out_valid;
    logic            out_ready;
    logic [LOGS-1:0] out_idx;
    logic            out_last;
    logic [LOGS:0]   out_cnt;
    logic            out_empty;

    encoder_stream #(.logS(LOGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_idx),
        .out_last  (out_last),
        .out_cnt   (out_cnt),
        .out_empty (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [S-1:0] vec;
        int           n_beats;
        int           first_idx;
        int           last_idx;
    } vec_rec_t;

    typedef struct {
        logic [LOGS-1:0] idx;
        logic [LOGS:0]   cnt;
        logic            last;
        logic            empty;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    beats_seen = 0;
    int    first_seen = -1;
    int    last_seen  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ascending scan of the vector, one beat per set bit.
    task automatic push_model(input logic [S-1:0] vec);
        int    pc = 0;
        int    k  = 0;
        beat_t b;
        for (int i = 0; i < S; i++) if (vec[i]) pc++;
        for (int i = 0; i < S; i++) begin
            if (vec[i]) begin
                b.idx   = LOGS'(i);
                b.cnt   = (LOGS + 1)'(k);
                b.last  = (k == pc - 1);
                b.empty = 1'b0;
                exp_q.push_back(b);
                k++;
            end
        end
`ifdef ENCODER_STREAM_EMPTY_FLAG_EN
        if (pc == 0) begin
            b.idx   = '0;
            b.cnt   = '0;
            b.last  = 1'b1;
            b.empty = 1'b1;
            exp_q.push_back(b);
        end
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beat_t e;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out",       32'(out_idx),   32'(e.idx));
                check("out_cnt",   32'(out_cnt),   32'(e.cnt));
                check("out_last",  32'(out_last),  32'(e.last));
                check("out_empty", 32'(out_empty), 32'(e.empty));
            end
            if (beats_seen == 0) first_seen = int'(out_idx);
            last_seen = int'(out_idx);
            beats_seen++;
        end
    end

    // Returns #1 after the accepting edge.
    task automatic send(input logic [S-1:0] vec);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        beats_seen = 0;
        first_seen = -1;
        last_seen  = -1;
        push_model(vec);
        in_vec   = vec;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = '0;
    endtask

    task automatic drain();
        int cycles = 0;
        while ((exp_q.size() != 0 || out_valid) && cycles < 200) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        check("drain_done", 32'(exp_q.size() != 0 || out_valid), 32'd0);
        exp_q.delete();
    endtask

    vec_rec_t tbl[7];

    initial begin
        tbl[0] = '{16'h8421, 4,  0, 15};
        tbl[1] = '{16'hFFFF, 16, 0, 15};
        tbl[2] = '{16'h0001, 1,  0, 0};
        tbl[3] = '{16'h8000, 1,  15, 15};
        tbl[4] = '{16'h00A0, 2,  5, 7};
        tbl[5] = '{16'h1248, 4,  3, 12};
        tbl[6] = '{16'h7FFE, 14, 1, 14};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out",       32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        check("rst_out_empty", 32'(out_empty), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // One-hot: first beat one cycle after acceptance, in_ready back two cycles after.
        send(16'h0100);
        check("onehot_in_ready_busy", 32'(in_ready),  32'd0);
        check("onehot_out_valid",     32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("onehot_in_ready_back", 32'(in_ready), 32'd1);
        check("onehot_beats", 32'(beats_seen), 32'd1);
        drain();

        for (int t = 0; t < 7; t++) begin
            send(tbl[t].vec);
            drain();
            check("tbl_beats", 32'(beats_seen), 32'(tbl[t].n_beats));
            check("tbl_first", 32'(first_seen), 32'(tbl[t].first_idx));
            check("tbl_last",  32'(last_seen),  32'(tbl[t].last_idx));
        end

        // Backpressure: beat held stable for three stalled edges.
        out_ready = 1'b0;
        send(16'h0006);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_out",   32'(out_idx),   32'd1);
            check("bp_last",  32'(out_last),  32'd0);
            check("bp_cnt",   32'(out_cnt),   32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("bp_beats", 32'(beats_seen), 32'd2);
        check("bp_final", 32'(last_seen),  32'd2);

        // Zero vector.
        send(16'h0000);
`ifdef ENCODER_STREAM_EMPTY_FLAG_EN
        drain();
        check("zero_beats", 32'(beats_seen), 32'd1);
`else
        check("zero_in_ready",  32'(in_ready),  32'd1);
        check("zero_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("zero_out_valid_late", 32'(out_valid), 32'd0);
        check("zero_beats", 32'(beats_seen), 32'd0);
        drain();
`endif

        // Reset after the second beat of 0x00F0: indices 6 and 7 must never appear.
        send(16'h00F0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_cnt",   32'(out_cnt),   32'd0);
        check("mid_rst_beats",     32'(beats_seen), 32'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_no_stale",  32'(beats_seen), 32'd2);

        send(16'h0003);
        drain();
        check("recover_beats", 32'(beats_seen), 32'd2);
        check("recover_last",  32'(last_seen),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
